mac_job_sched: RTL

- Round-robin job scheduler that shares one mac_unit (C = A x B, M x K x N) between NUM_REQ requesters.
- Each requester owns its own A/B/C memory bank. The scheduler grants one requester at a time and steers the bank muxes with bank_sel.
- It sequences mac_compute / mac_done and reports per-requester completion.
- A watchdog aborts a hung job and soft-resets the MAC.

---
 rtl/mac_sched_pkg.sv | 19 +
 rtl/mac_job_sched_rr_arbiter.sv | 43 ++++
 rtl/mac_job_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC job scheduler: FSM state encoding and index-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_e;

    // Width of an index into n requesters; never below 1 so a vector can be declared.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_job_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set req bit searching upward from ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the grant and advance ptr.
//
// Ports:
//   req     - request vector
//   ptr     - index where the search starts (highest priority this round)
//   gnt     - one-hot grant, all zero when no request
//   idx     - binary index of the granted bit (0 when none)
//   gnt_vld - high when any request was found
module rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             gnt_vld
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        idx     = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt[j]  = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mac_job_sched.sv
// Round-robin job scheduler sharing one mac_unit between NUM_REQ requesters, with watchdog abort.
// Latency: req sampled at edge t -> gnt at t; mac_compute rises SETUP_CYCLES edges later.
// Backpressure: requesters hold req until done/err; new grants only issue from IDLE.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   req           - per-requester level request
//   gnt           - one-hot grant held through SETUP and BUSY
//   done / err    - one-cycle completion / watchdog-abort pulses for the granted requester
//   bank_sel      - index of the last granted requester, steers the bank muxes
//   mac_compute   - start/hold to mac_unit, high only in BUSY
//   mac_done      - completion from mac_unit, only looked at in BUSY
//   mac_soft_rst  - one-cycle pulse resetting mac_unit on abort
//   busy          - high in any state except IDLE
//   job_cnt       - wrapping count of normally completed jobs
module mac_job_sched
    import mac_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          err,
    output logic [idx_w(NUM_REQ)-1:0]   bank_sel,
    output logic                        mac_compute,
    input  logic                        mac_done,
    output logic                        mac_soft_rst,
    output logic                        busy,
    output logic [CNT_W-1:0]            job_cnt
);

    localparam int IDX_W   = idx_w(NUM_REQ);
    // One counter serves both the SETUP wait and the BUSY watchdog.
    localparam int CYC_MAX = (TIMEOUT > SETUP_CYCLES) ? TIMEOUT : SETUP_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CYC_W-1:0] SETUP_END = CYC_W'(SETUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] WD_END    = CYC_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     bank_sel_q, bank_sel_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [CNT_W-1:0]     job_cnt_q, job_cnt_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_vld;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .gnt_vld (arb_vld)
    );

    // State register (with the datapath registers it owns).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            bank_sel_q <= '0;
            rr_q       <= '0;
            cyc_q      <= '0;
            job_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            bank_sel_q <= bank_sel_d;
            rr_q       <= rr_d;
            cyc_q      <= cyc_d;
            job_cnt_q  <= job_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        bank_sel_d = bank_sel_q;
        rr_d       = rr_q;
        cyc_d      = cyc_q;
        job_cnt_d  = job_cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d    = SETUP;
                    gnt_d      = arb_gnt;
                    bank_sel_d = arb_idx;
                    rr_d       = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                    cyc_d      = '0;
                end
            end
            SETUP: begin
                if (cyc_q == SETUP_END) begin
                    state_d = BUSY;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            BUSY: begin
                // mac_done is checked first so it wins over a coincident timeout.
                // gnt is dropped on leaving BUSY so it is already low in DONE/ABORT.
                if (mac_done) begin
                    state_d   = DONE;
                    gnt_d     = '0;
                    job_cnt_d = job_cnt_q + 1'b1;
                end else if (cyc_q == WD_END) begin
                    state_d = ABORT;
                    gnt_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        done         = '0;
        err          = '0;
        gnt          = gnt_q;
        bank_sel     = bank_sel_q;
        job_cnt      = job_cnt_q;
        mac_compute  = (state_q == BUSY);
        mac_soft_rst = (state_q == ABORT);
        busy         = (state_q != IDLE);
        if (state_q == DONE) begin
            done[bank_sel_q] = 1'b1;
        end
        if (state_q == ABORT) begin
            err[bank_sel_q] = 1'b1;
        end
    end

endmodule
